// File: rtl/fifo_rd_arbiter_pkg.sv
// Shared definitions for the FIFO read-port arbiter: FSM encodings and width helpers.
package fifo_rd_arbiter_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_BURST    = 2'd1;
  localparam logic [1:0] ST_HANDOVER = 2'd2;

  // Bits needed to hold a counter that must reach max_val
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_id, wrapping modulo NUM_REQ.
module fifo_rd_arbiter_rr_pick
  import fifo_rd_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_id,
  output logic [ID_W-1:0]    winner,
  output logic               any
);

  int idx_s;

  // Scan last_id+1 .. last_id+NUM_REQ; the first hit sticks because any is already set afterwards
  always_comb begin
    winner = {ID_W{1'b0}};
    any    = 1'b0;
    idx_s  = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx_s  = (int'(last_id) + i) % NUM_REQ;
      winner = (!any && req[idx_s]) ? ID_W'(idx_s) : winner;
      any    = any | req[idx_s];
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin burst arbiter sharing the async FIFO read port among NUM_REQ consumers,
// with read-valid strobes delayed to match the FIFO memory read latency.
module fifo_rd_arbiter
  import fifo_rd_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int MAX_BURST     = 4,
  parameter int EMPTY_TIMEOUT = 8,
  parameter int RD_LAT        = 1
) (
  input  logic                       rclk,
  input  logic                       rrst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       rempty,
  output logic                       rinc,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic [NUM_REQ-1:0]         rvalid,
  output logic                       burst_done
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int PC_W = cnt_width(MAX_BURST);
  localparam int EC_W = cnt_width(EMPTY_TIMEOUT);
  localparam logic [NUM_REQ-1:0] ONE_OH = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [1:0]         state_r;
  logic [NUM_REQ-1:0] gnt_r;
  logic [ID_W-1:0]    gnt_id_r;
  logic [ID_W-1:0]    last_id_r;
  logic [PC_W-1:0]    pop_cnt_r;
  logic [EC_W-1:0]    empty_cnt_r;
  logic               burst_done_r;
  logic [NUM_REQ-1:0] rv_pipe_r [RD_LAT];

  logic [ID_W-1:0]    winner_s;
  logic               any_s;
  logic [NUM_REQ-1:0] winner_oh_s;
  logic               req_own_s;
  logic               rinc_s;
  logic [PC_W-1:0]    pop_nxt_s;
  logic [EC_W-1:0]    empty_nxt_s;
  logic               exit_s;

  fifo_rd_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req     (req),
    .last_id (last_id_r),
    .winner  (winner_s),
    .any     (any_s)
  );

  // Pop decision and burst-exit conditions; a pop always clears the empty streak
  always_comb begin
    req_own_s   = req[gnt_id_r];
    rinc_s      = (state_r == ST_BURST) & req_own_s & ~rempty;
    pop_nxt_s   = pop_cnt_r + PC_W'(rinc_s);
    winner_oh_s = ONE_OH << winner_s;
    if (rinc_s) begin
      empty_nxt_s = {EC_W{1'b0}};
    end else if (req_own_s & rempty) begin
      empty_nxt_s = empty_cnt_r + EC_W'(1'b1);
    end else begin
      empty_nxt_s = empty_cnt_r;
    end
    exit_s = ~req_own_s
           | (pop_nxt_s == PC_W'(MAX_BURST))
           | (empty_nxt_s == EC_W'(EMPTY_TIMEOUT));
  end

  // Grant FSM: IDLE picks, BURST pops, HANDOVER forces one dead cycle between grants
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_r      <= ST_IDLE;
      gnt_r        <= {NUM_REQ{1'b0}};
      gnt_id_r     <= {ID_W{1'b0}};
      last_id_r    <= ID_W'(NUM_REQ - 1);
      pop_cnt_r    <= {PC_W{1'b0}};
      empty_cnt_r  <= {EC_W{1'b0}};
      burst_done_r <= 1'b0;
    end else begin
      burst_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (any_s) begin
            state_r     <= ST_BURST;
            gnt_r       <= winner_oh_s;
            gnt_id_r    <= winner_s;
            last_id_r   <= winner_s;
            pop_cnt_r   <= {PC_W{1'b0}};
            empty_cnt_r <= {EC_W{1'b0}};
          end
        end
        ST_BURST: begin
          if (exit_s) begin
            state_r      <= ST_HANDOVER;
            gnt_r        <= {NUM_REQ{1'b0}};
            burst_done_r <= 1'b1;
            pop_cnt_r    <= {PC_W{1'b0}};
            empty_cnt_r  <= {EC_W{1'b0}};
          end else begin
            pop_cnt_r   <= pop_nxt_s;
            empty_cnt_r <= empty_nxt_s;
          end
        end
        ST_HANDOVER: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          gnt_r   <= {NUM_REQ{1'b0}};
        end
      endcase
    end
  end

  // Read-valid delay line; the owner is latched at pop time so late data still reaches it
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        rv_pipe_r[i] <= {NUM_REQ{1'b0}};
      end
    end else begin
      rv_pipe_r[0] <= rinc_s ? gnt_r : {NUM_REQ{1'b0}};
      for (int i = 1; i < RD_LAT; i++) begin
        rv_pipe_r[i] <= rv_pipe_r[i-1];
      end
    end
  end

  assign rinc       = rinc_s;
  assign gnt        = gnt_r;
  assign gnt_id     = gnt_id_r;
  assign rvalid     = rv_pipe_r[RD_LAT-1];
  assign burst_done = burst_done_r;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter: behavioural grant/pop model compared every cycle,
// plus directed scenarios with hand-computed grant orders, pop counts and timings.
module tb_fifo_rd_arbiter;

  localparam int NUM_REQ       = 4;
  localparam int MAX_BURST     = 4;
  localparam int EMPTY_TIMEOUT = 8;
  localparam int RD_LAT        = 1;

  logic       rclk = 1'b0;
  logic       rrst = 1'b0;
  logic [3:0] req  = 4'b0000;
  logic       rempty;
  logic       rinc;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic [3:0] rvalid;
  logic       burst_done;

  int pushed_total = 0;
  int popped_total = 0;
  int fifo_cnt;
  assign fifo_cnt = pushed_total - popped_total;
  assign rempty   = (fifo_cnt == 0);

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 rclk = ~rclk;

  fifo_rd_arbiter #(
    .NUM_REQ       (NUM_REQ),
    .MAX_BURST     (MAX_BURST),
    .EMPTY_TIMEOUT (EMPTY_TIMEOUT),
    .RD_LAT        (RD_LAT)
  ) dut (
    .rclk       (rclk),
    .rrst       (rrst),
    .req        (req),
    .rempty     (rempty),
    .rinc       (rinc),
    .gnt        (gnt),
    .gnt_id     (gnt_id),
    .rvalid     (rvalid),
    .burst_done (burst_done)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  int  m_owner = -1;          // consumer currently holding the port, -1 if none
  int  m_last  = NUM_REQ - 1;
  int  m_pops, m_empties, m_cool;
  bit  m_done;
  int  due_q[$];              // cycle at which a popped word's data appears
  int  who_q[$];              // consumer the popped word belongs to
  bit  pop_seen;

  function automatic bit m_rinc();
    return (m_owner >= 0) && req[m_owner] && (fifo_cnt != 0);
  endfunction

  function automatic logic [3:0] m_gnt();
    logic [3:0] v;
    v = 4'b0000;
    if (m_owner >= 0) v[m_owner] = 1'b1;
    return v;
  endfunction

  function automatic logic [3:0] m_rvalid();
    logic [3:0] v;
    v = 4'b0000;
    foreach (due_q[i]) if (due_q[i] == cyc) v[who_q[i]] = 1'b1;
    return v;
  endfunction

  always @(posedge rclk or posedge rrst) begin
    bit p;
    bit found;
    int c;
    if (rrst) begin
      m_owner = -1; m_last = NUM_REQ - 1; m_pops = 0; m_empties = 0;
      m_cool = 0; m_done = 1'b0;
      due_q.delete(); who_q.delete();
    end else begin
      p = m_rinc();
      if (p) begin
        due_q.push_back(cyc + RD_LAT);
        who_q.push_back(m_owner);
      end
      m_done = 1'b0;
      if (m_owner >= 0) begin
        if (p) begin m_pops++; m_empties = 0; end
        else if (req[m_owner]) m_empties++;
        if (!req[m_owner] || m_pops == MAX_BURST || m_empties == EMPTY_TIMEOUT) begin
          m_owner = -1; m_done = 1'b1; m_cool = 1;
        end
      end else if (m_cool > 0) begin
        m_cool--;
      end else begin
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
          c = (m_last + k) % NUM_REQ;
          if (!found && req[c]) begin
            found = 1'b1; m_owner = c; m_last = c; m_pops = 0; m_empties = 0;
          end
        end
      end
      cyc++;
      while (due_q.size() > 0 && due_q[0] < cyc) begin
        void'(due_q.pop_front());
        void'(who_q.pop_front());
      end
      if (pop_seen) popped_total <= popped_total + 1;
    end
  end

  // ---------------- per-cycle compare + scenario logs ----------------
  int         id_log[$];
  int         rise_q[$];
  int         fall_q[$];
  int         pops_by[4];
  int         rv_by[4];
  logic [3:0] prev_gnt = 4'b0000;

  always @(negedge rclk) begin
    if (rrst) begin
      pop_seen = 1'b0;
      prev_gnt = 4'b0000;
    end else begin
      pop_seen = rinc;
      check("gnt", int'(gnt), int'(m_gnt()));
      check("rinc", int'(rinc), int'(m_rinc()));
      check("rvalid", int'(rvalid), int'(m_rvalid()));
      check("burst_done", int'(burst_done), int'(m_done));
      if (m_owner >= 0) check("gnt_id", int'(gnt_id), m_owner);
      check("gnt_onehot", int'($countones(gnt) <= 1), 1);
      check("rinc_while_empty", int'(rinc & rempty), 0);
      if (gnt != 4'b0000 && prev_gnt == 4'b0000) begin
        rise_q.push_back(cyc);
        id_log.push_back(int'(gnt_id));
      end
      if (gnt == 4'b0000 && prev_gnt != 4'b0000) fall_q.push_back(cyc);
      if (rinc) pops_by[gnt_id]++;
      for (int i = 0; i < 4; i++) if (rvalid[i]) rv_by[i]++;
      prev_gnt = gnt;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge rclk);
    #1;
  endtask

  task automatic clear_logs();
    id_log.delete(); rise_q.delete(); fall_q.delete();
    for (int i = 0; i < 4; i++) begin pops_by[i] = 0; rv_by[i] = 0; end
  endtask

  task automatic set_fifo(input int n);
    pushed_total = popped_total + n;
  endtask

  task automatic do_reset();
    req  = 4'b0000;
    rrst = 1'b1;
    cycles(1);
    check("rst_gnt", int'(gnt), 0);
    check("rst_gnt_id", int'(gnt_id), 0);
    check("rst_rvalid", int'(rvalid), 0);
    check("rst_burst_done", int'(burst_done), 0);
    check("rst_rinc", int'(rinc), 0);
    cycles(1);
    rrst = 1'b0;
    cycles(1);
  endtask

  initial begin
    do_reset();

    // Two requesters, ample data: 0 then 2, four pops each
    clear_logs();
    set_fifo(10);
    req = 4'b0101;
    cycles(12);
    req = 4'b0000;
    cycles(4);
    check("t1_grants", id_log.size(), 2);
    if (id_log.size() >= 2) begin
      check("t1_first", id_log[0], 0);
      check("t1_second", id_log[1], 2);
      check("t1_gap", rise_q[1] - fall_q[0], 2);
    end
    check("t1_pops0", pops_by[0], 4);
    check("t1_pops2", pops_by[2], 4);

    // Request dropped after two pops
    clear_logs();
    set_fifo(10);
    req = 4'b0010;
    cycles(3);
    req = 4'b0000;
    cycles(4);
    check("t2_pops1", pops_by[1], 2);
    check("t2_rvalid1", rv_by[1], 2);

    // Empty throughout: timeout after 8 cycles, re-grant 2 cycles later
    clear_logs();
    set_fifo(0);
    req = 4'b0100;
    cycles(14);
    req = 4'b0000;
    cycles(3);
    check("t3_pops", pops_by[2], 0);
    check("t3_grants", rise_q.size(), 2);
    if (rise_q.size() >= 2 && fall_q.size() >= 1) begin
      check("t3_hold", fall_q[0] - rise_q[0], 8);
      check("t3_regrant_gap", rise_q[1] - fall_q[0], 2);
    end

    // All requesting from reset: order 0,1,2,3,0
    do_reset();
    clear_logs();
    set_fifo(100);
    req = 4'b1111;
    cycles(27);
    req = 4'b0000;
    cycles(4);
    check("t4_grants", id_log.size(), 5);
    if (id_log.size() >= 5) begin
      for (int i = 0; i < 5; i++) check("t4_order", id_log[i], i % 4);
    end
    check("t4_pops0", pops_by[0], 6);
    check("t4_pops1", pops_by[1], 4);
    check("t4_pops2", pops_by[2], 4);
    check("t4_pops3", pops_by[3], 4);

    // Reset mid-burst while popping, then consumer 0 wins again
    clear_logs();
    req = 4'b0001;
    cycles(2);
    check("t5_rinc_before", int'(rinc), 1);
    rrst = 1'b1;
    #1;
    check("t5_gnt", int'(gnt), 0);
    check("t5_rinc", int'(rinc), 0);
    check("t5_rvalid", int'(rvalid), 0);
    cycles(2);
    rrst = 1'b0;
    clear_logs();
    req = 4'b1111;
    cycles(3);
    check("t5_winner_valid", id_log.size(), 1);
    if (id_log.size() >= 1) check("t5_winner", id_log[0], 0);
    req = 4'b0000;
    cycles(4);

    // Two words, runs dry, a late push resumes popping, then timeout
    clear_logs();
    set_fifo(2);
    req = 4'b1000;
    cycles(5);
    pushed_total = pushed_total + 1;
    cycles(12);
    req = 4'b0000;
    cycles(4);
    check("t6_pops3", pops_by[3], 3);
    if (rise_q.size() >= 1 && fall_q.size() >= 1) check("t6_hold", fall_q[0] - rise_q[0], 13);
    else check("t6_hold_seen", 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
